// File: rtl/apb_pkg.sv
// Shared types and constants for the APB bring-up subsystem.
// Address layout: bit 8 out-of-range flag, bit 7 slave select, bits 6:0 byte offset.
package apb_pkg;

    localparam int ADDR_WIDTH  = 9;
    localparam int DATA_WIDTH  = 8;
    localparam int ERR_BIT     = 8;
    localparam int SEL_BIT     = 7;
    localparam int OFFSET_MSB  = 6;
    localparam int OFFSET_W    = OFFSET_MSB + 1;
    localparam int SLAVE_DEPTH = 1 << OFFSET_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slave.sv
// APB byte memory slave; never reports an error.
// APB_WAIT_STATE_EN adds exactly one wait state to every access.
module apb_slave
    import apb_pkg::*;
(
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [OFFSET_W-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    logic [DATA_WIDTH-1:0] mem_q [SLAVE_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SLAVE_DEPTH];
    logic                  wr_en;

`ifdef APB_WAIT_STATE_EN
    // wait_done_q is high on the second ACCESS cycle only
    logic wait_done_q;
    logic wait_done_d;

    always_comb wait_done_d = psel & penable & ~wait_done_q;

    always_ff @(posedge pclk) begin
        if (presetn) wait_done_q <= 1'b0;
        else         wait_done_q <= wait_done_d;
    end

    assign pready = psel & penable & wait_done_q;
`else
    assign pready = psel & penable;
`endif

    assign pslverr = 1'b0;
    assign prdata  = mem_q[paddr];
    assign wr_en   = psel & penable & pready & pwrite;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[paddr] = pwdata;
    end

    always_ff @(posedge pclk) begin
        if (presetn) mem_q <= '{default: '0};
        else         mem_q <= mem_d;
    end

endmodule

// File: rtl/apb_top.sv
// APB master FSM and address decoder driving two apb_slave memories.
// Optional build macro APB_WAIT_STATE_EN (applies inside apb_slave).
//
// state  | meaning
// IDLE   | no transfer; waits for transfer with exactly one of read/write
// SETUP  | psel asserted, penable low, address/data/direction latched
// ACCESS | penable high; completes when pready (internal for bad address)
module apb_top
    import apb_pkg::*;
(
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  transfer,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] apb_write_paddr,
    input  logic [DATA_WIDTH-1:0] apb_write_data,
    input  logic [ADDR_WIDTH-1:0] apb_read_paddr,
    output logic                  pslverr,
    output logic [DATA_WIDTH-1:0] apb_read_data_out
);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  req_valid, req_conflict;
    logic                  psel1, psel2, penable, pready, done, addr_err, bus_err;
    logic                  pready1, pready2, pslverr1, pslverr2;
    logic [DATA_WIDTH-1:0] prdata1, prdata2, prdata;

    assign req_valid    = transfer & (read ^ write);
    assign req_conflict = transfer & read & write;

    always_ff @(posedge pclk) begin
        if (presetn) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            pslverr_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            pslverr_q <= pslverr_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = req_valid ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range addresses select no slave; the master completes them itself.
    always_comb begin
        addr_err = paddr_q[ERR_BIT];
        psel1    = (state_q != IDLE) & ~addr_err & ~paddr_q[SEL_BIT];
        psel2    = (state_q != IDLE) & ~addr_err &  paddr_q[SEL_BIT];
        penable  = (state_q == ACCESS);
        pready   = addr_err | (paddr_q[SEL_BIT] ? pready2 : pready1);
        prdata   = paddr_q[SEL_BIT] ? prdata2 : prdata1;
        bus_err  = addr_err | (paddr_q[SEL_BIT] ? pslverr2 : pslverr1);
        done     = penable & pready;
    end

    always_comb begin
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        pslverr_d = pslverr_q;
        rdata_d   = rdata_q;
        if (req_valid && (state_q == IDLE || done)) begin
            paddr_d  = write ? apb_write_paddr : apb_read_paddr;
            pwrite_d = write;
            if (write) pwdata_d = apb_write_data;
        end
        if (done) begin
            pslverr_d = bus_err;
            if (!pwrite_q && !bus_err) rdata_d = prdata;
        end else if (state_q == IDLE && req_conflict) begin
            pslverr_d = 1'b1;
        end
    end

    assign pslverr           = pslverr_q;
    assign apb_read_data_out = rdata_q;

    apb_slave u_slave1 (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel1),
        .penable (penable),
        .pwrite  (pwrite_q),
        .paddr   (paddr_q[OFFSET_MSB:0]),
        .pwdata  (pwdata_q),
        .prdata  (prdata1),
        .pready  (pready1),
        .pslverr (pslverr1)
    );

    apb_slave u_slave2 (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel2),
        .penable (penable),
        .pwrite  (pwrite_q),
        .paddr   (paddr_q[OFFSET_MSB:0]),
        .pwdata  (pwdata_q),
        .prdata  (prdata2),
        .pready  (pready2),
        .pslverr (pslverr2)
    );

endmodule

// File: tb/tb_apb_top.sv
// Self-checking bench for apb_top: directed scenarios plus random traffic
// compared against a flat 256-byte reference memory.
module tb_apb_top;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       transfer, read, write;
    logic [8:0] apb_write_paddr, apb_read_paddr;
    logic [7:0] apb_write_data;
    logic       pslverr;
    logic [7:0] apb_read_data_out;

    int checks = 0;
    int errors = 0;

`ifdef APB_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    logic [7:0] model_mem [256];
    logic       model_err;
    logic [7:0] model_rd;

    always #5 pclk = ~pclk;

    apb_top dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .transfer          (transfer),
        .read              (read),
        .write             (write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .pslverr           (pslverr),
        .apb_read_data_out (apb_read_data_out)
    );

    task automatic model_reset();
        foreach (model_mem[i]) model_mem[i] = 8'h00;
        model_err = 1'b0;
        model_rd  = 8'h00;
    endtask

    task automatic model_op(input bit wr, input logic [8:0] a, input logic [7:0] d);
        if (a[8]) begin
            model_err = 1'b1;
        end else begin
            model_err = 1'b0;
            if (wr) model_mem[a[7:0]] = d;
            else    model_rd = model_mem[a[7:0]];
        end
    endtask

    task automatic drive_idle();
        transfer = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
    endtask

    // The unused address port gets a different value so a wrong mux shows up.
    task automatic set_req(input bit wr, input logic [8:0] a, input logic [7:0] d);
        transfer = 1'b1;
        read     = !wr;
        write    = wr;
        if (wr) begin
            apb_write_paddr = a;
            apb_write_data  = d;
            apb_read_paddr  = a ^ 9'h0C3;
        end else begin
            apb_read_paddr  = a;
            apb_write_paddr = a ^ 9'h0C3;
            apb_write_data  = ~d;
        end
    endtask

    function automatic int nwait(input logic [8:0] a);
        return a[8] ? 0 : WS;
    endfunction

    // Single transfer with transfer dropped during SETUP; returns #1 after completion.
    task automatic do_xfer(input bit wr, input logic [8:0] a, input logic [7:0] d);
        @(negedge pclk);
        set_req(wr, a, d);
        @(posedge pclk);
        @(negedge pclk);
        drive_idle();
        @(posedge pclk);
        repeat (nwait(a)) @(posedge pclk);
        @(posedge pclk);
        #1;
        model_op(wr, a, d);
    endtask

    function automatic logic [8:0] rand_addr();
        logic [8:0] a;
        if ($urandom_range(0, 9) == 0) a = {1'b1, 8'($urandom)};
        else a = {1'b0, 1'($urandom), 4'b0000, 3'($urandom)};
        return a;
    endfunction

    task automatic test_reset();
        presetn = 1'b1;
        drive_idle();
        apb_write_paddr = '0;
        apb_read_paddr  = '0;
        apb_write_data  = '0;
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        checks++;
        if (pslverr !== 1'b0) begin
            errors++;
            $display("FAIL reset_pslverr: got %b expected 0", pslverr);
        end
        checks++;
        if (apb_read_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 00", apb_read_data_out);
        end
        @(negedge pclk);
        presetn = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if (pslverr !== 1'b0 || apb_read_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle_hold: got err=%b data=%h expected 0/00", pslverr, apb_read_data_out);
        end
    endtask

    task automatic test_write_read();
        do_xfer(1'b1, 9'h005, 8'hAA);
        checks++;
        if (pslverr !== 1'b0) begin
            errors++;
            $display("FAIL wr005_err: got %b expected 0", pslverr);
        end
        // read with cycle-accurate latency check
        @(negedge pclk);
        set_req(1'b0, 9'h005, 8'h00);
        @(posedge pclk);
        @(negedge pclk);
        drive_idle();
        @(posedge pclk);
        repeat (WS) @(posedge pclk);
        #1;
        checks++;
        if (apb_read_data_out !== 8'h00) begin
            errors++;
            $display("FAIL rd005_early: got %h expected 00 before completion", apb_read_data_out);
        end
        @(posedge pclk);
        #1;
        model_op(1'b0, 9'h005, 8'h00);
        checks++;
        if (apb_read_data_out !== 8'hAA || apb_read_data_out !== model_rd) begin
            errors++;
            $display("FAIL rd005_data: got %h expected AA", apb_read_data_out);
        end
        do_xfer(1'b1, 9'h005, 8'hA5);
        do_xfer(1'b1, 9'h085, 8'h5A);
        do_xfer(1'b0, 9'h005, 8'h00);
        checks++;
        if (apb_read_data_out !== 8'hA5 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL rd_slave1: got %h/%b expected A5/0", apb_read_data_out, pslverr);
        end
        do_xfer(1'b0, 9'h085, 8'h00);
        checks++;
        if (apb_read_data_out !== 8'h5A || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL rd_slave2: got %h/%b expected 5A/0", apb_read_data_out, pslverr);
        end
    endtask

    task automatic test_boundary();
        do_xfer(1'b1, 9'h010, 8'h11);
        do_xfer(1'b0, 9'h010, 8'h00);
        checks++;
        if (apb_read_data_out !== 8'h11) begin
            errors++;
            $display("FAIL rd010: got %h expected 11", apb_read_data_out);
        end
        do_xfer(1'b1, 9'h020, 8'h22);
        do_xfer(1'b0, 9'h020, 8'h00);
        checks++;
        if (apb_read_data_out !== 8'h22) begin
            errors++;
            $display("FAIL rd020: got %h expected 22", apb_read_data_out);
        end
        do_xfer(1'b1, 9'h1FF, 8'hFF);
        checks++;
        if (pslverr !== 1'b1 || apb_read_data_out !== 8'h22) begin
            errors++;
            $display("FAIL wr1FF: got err=%b data=%h expected 1/22", pslverr, apb_read_data_out);
        end
        do_xfer(1'b0, 9'h07F, 8'h00);
        checks++;
        if (apb_read_data_out !== 8'h00 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL rd07F: got %h/%b expected 00/0", apb_read_data_out, pslverr);
        end
        do_xfer(1'b0, 9'h0FF, 8'h00);
        checks++;
        if (apb_read_data_out !== 8'h00 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL rd0FF: got %h/%b expected 00/0", apb_read_data_out, pslverr);
        end
        do_xfer(1'b0, 9'h15A, 8'h00);
        checks++;
        if (pslverr !== 1'b1 || apb_read_data_out !== 8'h00) begin
            errors++;
            $display("FAIL rd_invalid: got %b/%h expected 1/00", pslverr, apb_read_data_out);
        end
    endtask

    task automatic run_b2b(input int n, input bit rnd);
        bit         wrs [64];
        logic [8:0] as  [64];
        logic [7:0] ds  [64];
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                wrs[k] = 1'($urandom);
                as[k]  = rand_addr();
                ds[k]  = 8'($urandom);
            end else begin
                wrs[k] = 1'b1;
                as[k]  = 9'h010;
                ds[k]  = 8'h11;
            end
        end
        @(negedge pclk);
        set_req(wrs[0], as[0], ds[0]);
        @(posedge pclk);
        for (int k = 0; k < n; k++) begin
            @(negedge pclk);
            if (k + 1 < n) set_req(wrs[k+1], as[k+1], ds[k+1]);
            else drive_idle();
            @(posedge pclk);
            repeat (nwait(as[k])) @(posedge pclk);
            @(posedge pclk);
            #1;
            model_op(wrs[k], as[k], ds[k]);
            checks++;
            if (pslverr !== model_err || apb_read_data_out !== model_rd) begin
                errors++;
                $display("FAIL b2b_%0d (wr=%0b a=%h): got %b/%h expected %b/%h",
                         k, wrs[k], as[k], pslverr, apb_read_data_out, model_err, model_rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_b2b(3, 1'b0);
        do_xfer(1'b0, 9'h010, 8'h00);
        checks++;
        if (apb_read_data_out !== 8'h11) begin
            errors++;
            $display("FAIL b2b_idem: got %h expected 11", apb_read_data_out);
        end
        run_b2b(40, 1'b1);
    endtask

    task automatic test_random();
        bit         wr;
        logic [8:0] a;
        logic [7:0] d;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom);
            a  = rand_addr();
            d  = 8'($urandom);
            do_xfer(wr, a, d);
            checks++;
            if (pslverr !== model_err || apb_read_data_out !== model_rd) begin
                errors++;
                $display("FAIL rand_%0d (wr=%0b a=%h): got %b/%h expected %b/%h",
                         i, wr, a, pslverr, apb_read_data_out, model_err, model_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_xfer(1'b1, 9'h0C1, 8'h9C);
        do_xfer(1'b0, 9'h0C1, 8'h00);
        do_xfer(1'b1, 9'h1FF, 8'hFF);
        @(negedge pclk);
        set_req(1'b1, 9'h030, 8'h33);
        @(posedge pclk);
        @(negedge pclk);
        drive_idle();
        @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk);
        #1;
        model_reset();
        checks++;
        if (pslverr !== 1'b0 || apb_read_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_out: got %b/%h expected 0/00", pslverr, apb_read_data_out);
        end
        @(negedge pclk);
        presetn = 1'b0;
        do_xfer(1'b1, 9'h032, 8'h77);
        do_xfer(1'b0, 9'h032, 8'h00);
        do_xfer(1'b0, 9'h030, 8'h00);
        checks++;
        if (apb_read_data_out !== 8'h00 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_nowrite: got %h/%b expected 00/0", apb_read_data_out, pslverr);
        end
        do_xfer(1'b0, 9'h0C1, 8'h00);
        checks++;
        if (apb_read_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_memclr: got %h expected 00", apb_read_data_out);
        end
    endtask

    task automatic test_conflict();
        do_xfer(1'b0, 9'h032, 8'h00);
        @(negedge pclk);
        transfer        = 1'b1;
        read            = 1'b1;
        write           = 1'b1;
        apb_write_paddr = 9'h030;
        apb_write_data  = 8'hEE;
        apb_read_paddr  = 9'h032;
        @(posedge pclk);
        #1;
        checks++;
        if (pslverr !== 1'b1 || apb_read_data_out !== 8'h77) begin
            errors++;
            $display("FAIL conflict_err: got %b/%h expected 1/77", pslverr, apb_read_data_out);
        end
        @(negedge pclk);
        drive_idle();
        repeat (4) @(posedge pclk);
        #1;
        checks++;
        if (pslverr !== 1'b1 || apb_read_data_out !== 8'h77) begin
            errors++;
            $display("FAIL conflict_hold: got %b/%h expected 1/77", pslverr, apb_read_data_out);
        end
        model_err = 1'b1;
        do_xfer(1'b0, 9'h030, 8'h00);
        checks++;
        if (apb_read_data_out !== 8'h00 || pslverr !== 1'b0 || model_rd !== 8'h00) begin
            errors++;
            $display("FAIL conflict_nowrite: got %h/%b expected 00/0", apb_read_data_out, pslverr);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_boundary();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_conflict();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_top.md
Name: apb_top

Overview:
- Self-contained APB subsystem: an APB master FSM plus two identical APB memory slaves on a shared bus.
- Simple user-side controls (transfer/read/write with address and data) are converted into APB SETUP/ACCESS transfers.
- Read results and slave errors are returned on registered outputs.
- Used as a bring-up/demo block for APB protocol sequencing.

Parameters:
ADDR_WIDTH, 9, user/APB address width; bit 8 out-of-range flag, bit 7 slave select, bits 6:0 byte offset
DATA_WIDTH, 8, data width
SLAVE_DEPTH, 128, bytes per slave memory (2^(ADDR_WIDTH-2))

Ports:
pclk  input  1  system clock, all logic rising-edge
presetn  input  1  reset
transfer  input  1  request a transfer while high
read  input  1  request is a read
write  input  1  request is a write
apb_write_paddr  input  9  address for write requests
apb_write_data  input  8  write data
apb_read_paddr  input  9  address for read requests
pslverr  output  1  error status of the last completed transfer
apb_read_data_out  output  8  data of the last successful read

Interface: one clock; reset is synchronous and active-high (presetn high resets on a pclk edge). The port keeps the codebase name presetn despite its polarity.

Behaviour:
- Reset values:
  - FSM in IDLE; pslverr=0; apb_read_data_out=0.
  - Internal psel1/psel2/penable/pwrite=0; paddr/pwdata=0.
  - Both slave memories cleared to 0.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: if transfer=1 and exactly one of read/write is 1, go to SETUP; otherwise stay.
  - SETUP (1 cycle):
    - paddr = write ? apb_write_paddr : apb_read_paddr, registered at the IDLE->SETUP edge; pwrite, pwdata latched likewise.
    - Decoded psel asserted, penable=0. Always goes to ACCESS.
  - ACCESS:
    - penable=1 and psel held; address/data/pwrite held stable.
    - When pready=1, the transfer completes on that edge.
    - On completion: if transfer is still 1 with a valid read/write request, go to SETUP (back-to-back, re-sampling inputs); otherwise go to IDLE.
    - pready=0 keeps the FSM in ACCESS.
- Decode:
  - paddr[8]=1: invalid. No psel is asserted; the master completes ACCESS itself with an internal pready=1 and error=1.
  - paddr[8]=0: paddr[7]=0 selects slave1, paddr[7]=1 selects slave2; paddr[6:0] is the byte offset.
- Slaves:
  - Zero wait states: pready=1 whenever psel&penable. pslverr from a slave is always 0.
  - Write: mem[paddr[6:0]] <= pwdata at the completion edge.
  - Read: prdata = mem[paddr[6:0]], combinational during ACCESS.
- Outputs:
  - Each completion edge sets pslverr <= error of that transfer; it holds until the next completion.
  - On a successful read completion, apb_read_data_out <= prdata.
  - Writes and erroring reads leave apb_read_data_out unchanged.
- Latency: transfer sampled high in IDLE at edge N gives SETUP after N, ACCESS after N+1, completion at edge N+2.
- Simultaneous read=write=1 with transfer=1: no bus transfer; at the next edge pslverr<=1 and the FSM stays in IDLE.
- transfer dropping during SETUP/ACCESS: the current transfer still completes.
- Reset mid-operation: abort immediately to IDLE; memories cleared; no partial write.

Optional Feature:
APB_WAIT_STATE_EN:
- Defined: each slave inserts exactly one wait state (pready=0 on the first ACCESS cycle, 1 on the second), so completion moves to edge N+3. Invalid-address transfers still complete with no wait.
- Undefined: zero wait states as above.

Decomposition:
- Package apb_pkg:
  - State enum {IDLE, SETUP, ACCESS}.
  - ADDR_WIDTH, DATA_WIDTH.
  - Bit-position constants: ERR_BIT=8, SEL_BIT=7, OFFSET range 6:0.
- Sub-module apb_slave: psel, penable, pwrite, paddr[6:0], pwdata in; prdata, pready, pslverr out. Instantiated twice.
- Master FSM and decoder live in apb_top.

Test Plan:
- Reset held 2 cycles -> pslverr=0, apb_read_data_out=0, FSM IDLE.
- Write 0x005<=0xAA, then read 0x005 -> apb_read_data_out=0xAA on the completion edge (3rd edge after transfer rises); pslverr=0.
- Write 0x005<=0xA5 and 0x085<=0x5A, then read both -> 0xA5 and 0x5A respectively (distinct slaves, same offset).
- Write 0x010<=0x11, read 0x010 -> 0x11; write 0x020<=0x22, read 0x020 -> 0x22; transfer held 3 cycles gives back-to-back repeats, which are idempotent.
- Write to 0x1FF with data 0xFF -> pslverr=1 at completion, no memory changed (read 0x07F and 0x0FF return 0); next valid transfer clears pslverr to 0.
- Write 0x030<=0x33, assert reset during ACCESS -> IDLE next edge, outputs 0, read 0x030 returns 0; read=write=1 -> pslverr=1, no transfer.
